// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, opcodes/functs,
// and the select encodings understood by EXT, ALU, NPC and the GRF write muxes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JAL  = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_RA   = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_PC    = 2'b10;

    // One-hot instruction class; exactly one field is set for any Instr.
    typedef struct packed {
        logic rcal;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic jal;
        logic jr;
        logic unk;
    } instr_class_t;

    typedef struct packed {
        logic [1:0] extOp;
        logic [2:0] aluOp;
        logic       aluSrc;
        logic [1:0] npcOp;
        logic [1:0] regDst;
        logic [1:0] wdSel;
    } sel_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: classifies the held instruction and
// derives the datapath selects, which depend on Instr alone.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0]  i_instr,
    output instr_class_t o_cls,
    output sel_t         o_sel
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_unused;

    assign w_op     = i_instr[31:26];
    assign w_fn     = i_instr[5:0];
    assign w_unused = ^i_instr[25:6];

    always_comb begin
        o_cls = '0;
        case (w_op)
            OP_RTYPE: begin
                case (w_fn)
                    FN_ADDU, FN_SUBU: o_cls.rcal = 1'b1;
                    FN_JR:            o_cls.jr   = 1'b1;
                    default:          o_cls.unk  = 1'b1;
                endcase
            end
            OP_ORI:  o_cls.ori = 1'b1;
            OP_LUI:  o_cls.lui = 1'b1;
            OP_LW:   o_cls.lw  = 1'b1;
            OP_SW:   o_cls.sw  = 1'b1;
            OP_BEQ:  o_cls.beq = 1'b1;
            OP_JAL:  o_cls.jal = 1'b1;
            default: o_cls.unk = 1'b1;
        endcase
    end

    // All-zero encodings are the defaults, so only the non-zero cases are listed.
    always_comb begin
        o_sel        = '0;
        o_sel.aluSrc = o_cls.ori | o_cls.lui | o_cls.lw | o_cls.sw;

        if (o_cls.lw || o_cls.sw || o_cls.beq)
            o_sel.extOp = EXT_SIGN;
        else if (o_cls.lui)
            o_sel.extOp = EXT_LUI;

        if ((o_cls.rcal && (w_fn == FN_SUBU)) || o_cls.beq)
            o_sel.aluOp = ALU_SUB;
        else if (o_cls.ori || o_cls.lui)
            o_sel.aluOp = ALU_OR;

        if (o_cls.jal)
            o_sel.npcOp = NPC_JAL;
        else if (o_cls.jr)
            o_sel.npcOp = NPC_JR;
        else if (o_cls.beq)
            o_sel.npcOp = NPC_BR;

        if (o_cls.rcal)
            o_sel.regDst = DST_RD;
        else if (o_cls.jal)
            o_sel.regDst = DST_RA;

        if (o_cls.lw)
            o_sel.wdSel = WD_DM;
        else if (o_cls.jal)
            o_sel.wdSel = WD_PC;
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB state machine with
// combinational write strobes; selects come straight from the decoder.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    output logic        PCWr,
    output logic        IRWr,
    output logic [1:0]  NPCOp,
    output logic [1:0]  EXTOp,
    output logic [2:0]  ALUOp,
    output logic        ALUSrc,
    output logic        RegWr,
    output logic [1:0]  RegDst,
    output logic [1:0]  WDSel,
    output logic        MemWr,
    output logic        Done,
    output logic [2:0]  State
);

    state_e       r_state;
    state_e       w_next;
    instr_class_t w_cls;
    sel_t         w_sel;

    mc_decode u_decode (
        .i_instr (Instr),
        .o_cls   (w_cls),
        .o_sel   (w_sel)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    assign State = r_state;

    always_comb begin
        w_next = S_FETCH;
        PCWr   = 1'b0;
        IRWr   = 1'b0;
        RegWr  = 1'b0;
        MemWr  = 1'b0;
        Done   = 1'b0;
        EXTOp  = w_sel.extOp;
        ALUOp  = w_sel.aluOp;
        ALUSrc = w_sel.aluSrc;
        RegDst = w_sel.regDst;
        WDSel  = w_sel.wdSel;
        NPCOp  = (r_state == S_FETCH) ? NPC_PC4 : w_sel.npcOp;

        case (r_state)
            S_FETCH: begin
                IRWr   = 1'b1;
                PCWr   = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_cls.jal) begin
                    PCWr  = 1'b1;
                    RegWr = 1'b1;
                    Done  = 1'b1;
                end else if (w_cls.jr) begin
                    PCWr = 1'b1;
                    Done = 1'b1;
                end else if (w_cls.unk) begin
                    Done = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_cls.beq) begin
                    PCWr = Zero;
                    Done = 1'b1;
                end else if (w_cls.lw || w_cls.sw) begin
                    w_next = S_MEM;
                end else if (w_cls.rcal || w_cls.ori || w_cls.lui) begin
                    w_next = S_WB;
                end else begin
                    Done = 1'b1;
                end
            end
            S_MEM: begin
                if (w_cls.sw) begin
                    MemWr = 1'b1;
                    Done  = 1'b1;
                end else if (w_cls.lw) begin
                    w_next = S_WB;
                end else begin
                    Done = 1'b1;
                end
            end
            S_WB: begin
                RegWr = w_cls.rcal | w_cls.ori | w_cls.lui | w_cls.lw;
                Done  = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // A reset cycle must never leave a partial write behind.
        if (reset) begin
            PCWr   = 1'b0;
            IRWr   = 1'b0;
            RegWr  = 1'b0;
            MemWr  = 1'b0;
            Done   = 1'b0;
            NPCOp  = '0;
            EXTOp  = '0;
            ALUOp  = '0;
            ALUSrc = 1'b0;
            RegDst = '0;
            WDSel  = '0;
            w_next = S_FETCH;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed table, reset corner cases and
// randomized instructions against a path-per-instruction reference model.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic        Zero;
    logic        PCWr, IRWr, ALUSrc, RegWr, MemWr, Done;
    logic [1:0]  NPCOp, EXTOp, RegDst, WDSel;
    logic [2:0]  ALUOp, State;

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [31:0] curInstr    = '0;

    typedef enum int {C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_JR, C_UNK} cls_e;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          cycles;
    } vec_t;

    mc_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .Instr  (Instr),
        .Zero   (Zero),
        .PCWr   (PCWr),
        .IRWr   (IRWr),
        .NPCOp  (NPCOp),
        .EXTOp  (EXTOp),
        .ALUOp  (ALUOp),
        .ALUSrc (ALUSrc),
        .RegWr  (RegWr),
        .RegDst (RegDst),
        .WDSel  (WDSel),
        .MemWr  (MemWr),
        .Done   (Done),
        .State  (State)
    );

    always #5 clk = ~clk;

    function automatic cls_e classify(input logic [31:0] ins);
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h21:   return C_ADDU;
                    6'h23:   return C_SUBU;
                    6'h08:   return C_JR;
                    default: return C_UNK;
                endcase
            end
            6'h0D:   return C_ORI;
            6'h0F:   return C_LUI;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            6'h03:   return C_JAL;
            default: return C_UNK;
        endcase
    endfunction

    // Each instruction class walks a fixed sequence of states, one letter per cycle.
    function automatic string pathOf(input cls_e c);
        case (c)
            C_ADDU, C_SUBU, C_ORI, C_LUI: return "FDEW";
            C_LW:    return "FDEMW";
            C_SW:    return "FDEM";
            C_BEQ:   return "FDE";
            default: return "FD";
        endcase
    endfunction

    function automatic logic [2:0] stateCode(input byte s);
        case (s)
            "F":     return 3'd0;
            "D":     return 3'd1;
            "E":     return 3'd2;
            "M":     return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s instr=%08h: got %0h expected %0h", name, curInstr, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic z, input logic rst);
        Instr    = ins;
        Zero     = z;
        reset    = rst;
        curInstr = ins;
    endtask

    task automatic resync();
        applyStimulus(32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Runs one instruction from FETCH; doneCycle is the 1-based cycle where Done was first seen.
    task automatic runInstr(input logic [31:0] ins, input logic z, output int doneCycle);
        cls_e       c;
        string      path;
        byte        s;
        int         failsBefore;
        logic       expPc, expIr, expReg, expMem, expDone, expSrc;
        logic [1:0] expNpc, expDst, expWd, expExt;
        logic [2:0] expAlu;
        c           = classify(ins);
        path        = pathOf(c);
        doneCycle   = 0;
        failsBefore = testsFailed;
        expExt = (c == C_LW || c == C_SW || c == C_BEQ) ? 2'b01 : (c == C_LUI) ? 2'b10 : 2'b00;
        expSrc = (c == C_ORI || c == C_LUI || c == C_LW || c == C_SW);
        expAlu = (c == C_SUBU || c == C_BEQ) ? 3'b001 : (c == C_ORI || c == C_LUI) ? 3'b010 : 3'b000;
        expDst = (c == C_JAL) ? 2'b10 : (c == C_ADDU || c == C_SUBU) ? 2'b01 : 2'b00;
        expWd  = (c == C_JAL) ? 2'b10 : (c == C_LW) ? 2'b01 : 2'b00;
        applyStimulus(ins, z, 1'b0);
        for (int k = 0; k < path.len(); k++) begin
            s       = path[k];
            expIr   = (s == "F");
            expPc   = (s == "F") || (s == "D" && (c == C_JAL || c == C_JR)) || (s == "E" && c == C_BEQ && z);
            expReg  = (s == "D" && c == C_JAL) || (s == "W");
            expMem  = (s == "M" && c == C_SW);
            expDone = (k == path.len() - 1);
            expNpc  = (s == "F") ? 2'b00 : (c == C_JAL) ? 2'b10 : (c == C_JR) ? 2'b11 : 2'b01;
            @(negedge clk);
            checkOutput("State", {29'b0, State}, {29'b0, stateCode(s)});
            checkOutput("IRWr", {31'b0, IRWr}, {31'b0, expIr});
            checkOutput("PCWr", {31'b0, PCWr}, {31'b0, expPc});
            checkOutput("RegWr", {31'b0, RegWr}, {31'b0, expReg});
            checkOutput("MemWr", {31'b0, MemWr}, {31'b0, expMem});
            checkOutput("Done", {31'b0, Done}, {31'b0, expDone});
            checkOutput("EXTOp", {30'b0, EXTOp}, {30'b0, expExt});
            checkOutput("ALUSrc", {31'b0, ALUSrc}, {31'b0, expSrc});
            if (c != C_JAL && c != C_JR && c != C_UNK)
                checkOutput("ALUOp", {29'b0, ALUOp}, {29'b0, expAlu});
            if (expPc)
                checkOutput("NPCOp", {30'b0, NPCOp}, {30'b0, expNpc});
            if (expReg) begin
                checkOutput("RegDst", {30'b0, RegDst}, {30'b0, expDst});
                checkOutput("WDSel", {30'b0, WDSel}, {30'b0, expWd});
            end
            if (Done === 1'b1 && doneCycle == 0)
                doneCycle = k + 1;
            @(posedge clk);
            #1;
        end
        if (testsFailed != failsBefore)
            resync();
    endtask

    function automatic logic [31:0] randomInstr();
        logic [5:0] op;
        logic [5:0] fn;
        case ($urandom_range(0, 9))
            0: return {6'h00, 20'($urandom), 6'h21};
            1: return {6'h00, 20'($urandom), 6'h23};
            2: return {6'h0D, 26'($urandom)};
            3: return {6'h0F, 26'($urandom)};
            4: return {6'h23, 26'($urandom)};
            5: return {6'h2B, 26'($urandom)};
            6: return {6'h04, 26'($urandom)};
            7: return {6'h03, 26'($urandom)};
            8: return {6'h00, 5'($urandom), 15'h0, 6'h08};
            default: begin
                if ($urandom_range(0, 1) == 1) begin
                    fn = 6'($urandom);
                    if (fn == 6'h21 || fn == 6'h23 || fn == 6'h08)
                        fn = 6'h3F;
                    return {6'h00, 20'($urandom), fn};
                end
                op = 6'($urandom);
                return {op, 26'($urandom)};
            end
        endcase
    endfunction

    initial begin
        vec_t vecs[12];
        int   doneCycle;

        vecs[0]  = '{32'h3401FFFF, 1'b0, 4};
        vecs[1]  = '{32'h8C02FFFC, 1'b0, 5};
        vecs[2]  = '{32'hAC010004, 1'b0, 4};
        vecs[3]  = '{32'h3C031234, 1'b0, 4};
        vecs[4]  = '{32'h10220001, 1'b1, 3};
        vecs[5]  = '{32'h10220001, 1'b0, 3};
        vecs[6]  = '{32'h0C000C00, 1'b0, 2};
        vecs[7]  = '{32'h03E00008, 1'b0, 2};
        vecs[8]  = '{32'h00000000, 1'b0, 2};
        vecs[9]  = '{32'hFC000000, 1'b0, 2};
        vecs[10] = '{32'h00221821, 1'b0, 4};
        vecs[11] = '{32'h00221823, 1'b1, 4};

        // Reset held two cycles with a live instruction: strobes and selects stay 0.
        applyStimulus(32'h3401FFFF, 1'b1, 1'b1);
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            if (r == 1)
                checkOutput("rst State", {29'b0, State}, 32'd0);
            checkOutput("rst IRWr", {31'b0, IRWr}, 32'd0);
            checkOutput("rst PCWr", {31'b0, PCWr}, 32'd0);
            checkOutput("rst RegWr", {31'b0, RegWr}, 32'd0);
            checkOutput("rst MemWr", {31'b0, MemWr}, 32'd0);
            checkOutput("rst Done", {31'b0, Done}, 32'd0);
            checkOutput("rst ALUSrc", {31'b0, ALUSrc}, 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        foreach (vecs[i]) begin
            runInstr(vecs[i].instr, vecs[i].zero, doneCycle);
            curInstr = vecs[i].instr;
            checkOutput("cycles", doneCycle, vecs[i].cycles);
        end

        // Reset during MEM of sw must suppress MemWr and return to FETCH.
        applyStimulus(32'hAC010004, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
        end
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst State", {29'b0, State}, 32'd3);
        checkOutput("midrst MemWr", {31'b0, MemWr}, 32'd0);
        checkOutput("midrst Done", {31'b0, Done}, 32'd0);
        checkOutput("midrst RegWr", {31'b0, RegWr}, 32'd0);
        checkOutput("midrst PCWr", {31'b0, PCWr}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("postrst State", {29'b0, State}, 32'd0);
        checkOutput("postrst IRWr", {31'b0, IRWr}, 32'd1);
        checkOutput("postrst MemWr", {31'b0, MemWr}, 32'd0);
        @(posedge clk);
        #1;
        resync();

        for (int n = 0; n < 300; n++) begin
            runInstr(randomInstr(), 1'($urandom), doneCycle);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
